wb_arbiter_2m: RTL and testbench

- Two-master to one-slave arbiter for the pipelined Wishbone bus in front of the on-chip single-cycle memory.
- Master 0 is the instruction-fetch port; master 1 is the load/store port. Both share the single memory slave.
- Grants the bus per Wishbone cycle (held while the owner's cyc is high), round-robin on contention.
- Muxes the owner's request onto the slave, routes ack/err back to the owner, and bounds in-flight requests.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_outstanding_ctr.sv | 48 ++++
 rtl/wb_arbiter_2m.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone types for the on-chip bus: arbiter state encoding and
// request/response bundles at the default 32-bit data width.
package wb_pkg;

    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned WB_AW   = WB_XLEN - $clog2(WB_XLEN / 8);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   cyc;
        logic                   stb;
        logic                   we;
        logic [WB_AW-1:0]       addr;
        logic [WB_XLEN/8-1:0]   sel;
        logic [WB_XLEN-1:0]     dat;
    } wb_req_t;

    typedef struct packed {
        logic                   ack;
        logic                   err;
        logic                   stall;
        logic [WB_XLEN-1:0]     dat;
    } wb_rsp_t;

    function automatic arb_state_t own_of(input logic idx);
        return idx ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/wb_outstanding_ctr.sv
// Counts accepted-but-unretired bus requests, saturating at MAX_OUT.
// Retires on an empty counter are ignored so stray responses never underflow.
module wb_outstanding_ctr #(
    parameter int unsigned MAX_OUT = 4,
    localparam int unsigned CW     = $clog2(MAX_OUT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          accept_i,
    input  logic          retire_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUT);

    logic [CW-1:0] count_q, count_d;
    logic          inc, dec;

    assign full_o  = (count_q == MaxCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign inc = accept_i && !full_o;
    assign dec = retire_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc && !dec) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master pipelined Wishbone arbiter: grants per bus cycle, round-robin on
// contention, with a bounded number of in-flight requests to the slave.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = XLEN - $clog2(XLEN / 8),
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [XLEN/8-1:0] m0_sel_i,
    input  logic [XLEN-1:0]   m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_stall_o,
    output logic [XLEN-1:0]   m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [XLEN/8-1:0] m1_sel_i,
    input  logic [XLEN-1:0]   m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_stall_o,
    output logic [XLEN-1:0]   m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_addr_o,
    output logic [XLEN/8-1:0] s_sel_o,
    output logic [XLEN-1:0]   s_dat_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_stall_i,
    input  logic [XLEN-1:0]   s_dat_i
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned BW = 1 + AW + XLEN / 8 + XLEN;

    arb_state_t    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant;

    logic          req0, req1;
    logic          own0, own1;
    logic          owner_cyc, owner_stb;
    logic [BW-1:0] m0_bus, m1_bus, owner_bus;

    logic [CW-1:0] out_cnt;
    logic          full, empty;
    logic          accept, retire, clear;
    logic          fwd_ack0, fwd_err0, fwd_ack1, fwd_err1;

    assign req0 = m0_cyc_i && m0_stb_i;
    assign req1 = m1_cyc_i && m1_stb_i;
    assign own0 = (state_q == ARB_OWN0);
    assign own1 = (state_q == ARB_OWN1);

    // Ownership ends on the cycle the owner drops cyc; IDLE always separates owners.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant        = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0 || req1) begin
                    grant        = (req0 && req1) ? !last_grant_q : req1;
                    state_d      = own_of(grant);
                    last_grant_d = grant;
                end
            end
            ARB_OWN0: if (!m0_cyc_i) state_d = ARB_IDLE;
            ARB_OWN1: if (!m1_cyc_i) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m0_bus = {m0_we_i, m0_addr_i, m0_sel_i, m0_dat_i};
    assign m1_bus = {m1_we_i, m1_addr_i, m1_sel_i, m1_dat_i};

    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_bus = '0;
        unique case (state_q)
            ARB_OWN0: begin
                owner_cyc = m0_cyc_i;
                owner_stb = m0_stb_i;
                owner_bus = m0_bus;
            end
            ARB_OWN1: begin
                owner_cyc = m1_cyc_i;
                owner_stb = m1_stb_i;
                owner_bus = m1_bus;
            end
            default: ;
        endcase
    end

    assign s_cyc_o = owner_cyc;
    // Full is judged on the registered count; a same-cycle ack frees nothing yet.
    assign s_stb_o = owner_stb && !full;
    assign {s_we_o, s_addr_o, s_sel_o, s_dat_o} = owner_bus;

    assign m0_stall_o = own0 ? (s_stall_i || full) : 1'b1;
    assign m1_stall_o = own1 ? (s_stall_i || full) : 1'b1;

    // Responses with nothing outstanding are stale (aborted cycle) and dropped.
    assign fwd_ack0 = s_ack_i && own0 && !empty && m0_cyc_i;
    assign fwd_err0 = s_err_i && own0 && !empty && m0_cyc_i;
    assign fwd_ack1 = s_ack_i && own1 && !empty && m1_cyc_i;
    assign fwd_err1 = s_err_i && own1 && !empty && m1_cyc_i;

    assign m0_ack_o = fwd_ack0;
    assign m0_err_o = fwd_err0;
    assign m1_ack_o = fwd_ack1;
    assign m1_err_o = fwd_err1;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign accept = s_stb_o && !s_stall_i;
    assign retire = fwd_ack0 || fwd_err0 || fwd_ack1 || fwd_err1;
    assign clear  = (own0 && !m0_cyc_i) || (own1 && !m1_cyc_i);

    wb_outstanding_ctr #(
        .MAX_OUT (MAX_OUT)
    ) u_ctr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear),
        .accept_i (accept),
        .retire_i (retire),
        .count_o  (out_cnt),
        .full_o   (full),
        .empty_o  (empty)
    );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: a bench-side slave answers accepted
// requests in order; per-master expectation queues check every response.
module tb_wb_arbiter_2m;

    localparam int XLEN    = 32;
    localparam int AW      = 30;
    localparam int SW      = XLEN / 8;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic [SW-1:0]   m0_sel, m1_sel;
    logic [XLEN-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat;
    logic            m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_addr_o;
    logic [SW-1:0]   s_sel_o;
    logic [XLEN-1:0] s_dat_o, s_dat_i;
    logic            s_ack_i, s_err_i, s_stall_i;

    wb_arbiter_2m #(.XLEN(XLEN), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_stall_i(s_stall_i), .s_dat_i(s_dat_i)
    );

    typedef struct {
        logic            err;
        logic [XLEN-1:0] dat;
    } rsp_t;

    rsp_t slave_q[$];
    rsp_t exp0_q[$];
    rsp_t exp1_q[$];

    int total = 0;
    int bad   = 0;

    bit hold, inject_ack, stall_req;
    bit o_acc0, o_acc1, o_rsp0, o_rsp1, o_ack0, o_ack1, o_err0, o_err1;
    bit o_scyc, o_sstb, o_stall0, o_stall1;
    int o_cnt;
    int n_acc0 = 0, n_acc1 = 0, n_rsp0 = 0, n_rsp1 = 0, n_sstb = 0;
    int n_ack0 = 0, n_err0 = 0;

    function automatic logic [XLEN-1:0] rd_data(input logic [AW-1:0] a);
        return {2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic is_err(input logic we, input logic [AW-1:0] a);
        return we && (a == 30'h4000);
    endfunction

    // One clock: snapshot and score at negedge, then drive slave responses.
    task automatic cycle();
        rsp_t            r;
        rsp_t            e;
        logic [AW-1:0]   a;
        logic            w;
        logic [SW-1:0]   sl;
        logic [XLEN-1:0] wd;
        @(negedge clk);
        o_acc0   = m0_cyc && m0_stb && !m0_stall;
        o_acc1   = m1_cyc && m1_stb && !m1_stall;
        o_ack0   = m0_ack;
        o_ack1   = m1_ack;
        o_err0   = m0_err;
        o_err1   = m1_err;
        o_rsp0   = m0_ack || m0_err;
        o_rsp1   = m1_ack || m1_err;
        o_scyc   = s_cyc_o;
        o_sstb   = s_stb_o;
        o_stall0 = m0_stall;
        o_stall1 = m1_stall;
        o_cnt    = int'(dut.out_cnt);

        if (o_acc0 || o_acc1) begin
            a  = o_acc0 ? m0_addr : m1_addr;
            w  = o_acc0 ? m0_we : m1_we;
            sl = o_acc0 ? m0_sel : m1_sel;
            wd = o_acc0 ? m0_wdat : m1_wdat;
            total++;
            if (!(s_cyc_o && s_stb_o && !s_stall_i) || s_addr_o !== a || s_we_o !== w ||
                s_sel_o !== sl || (w && s_dat_o !== wd)) begin
                bad++;
                $display("FAIL fwd_req: got stb=%b addr=%h we=%b sel=%h, need addr=%h we=%b sel=%h",
                         s_stb_o, s_addr_o, s_we_o, s_sel_o, a, w, sl);
            end
            e.err = is_err(w, a);
            e.dat = rd_data(a);
            if (o_acc0) exp0_q.push_back(e);
            else        exp1_q.push_back(e);
        end
        if (s_cyc_o && s_stb_o && !s_stall_i) begin
            r.err = is_err(s_we_o, s_addr_o);
            r.dat = rd_data(s_addr_o);
            slave_q.push_back(r);
            n_sstb++;
        end

        if (o_rsp0) begin
            total++;
            if (exp0_q.size() == 0) begin
                bad++;
                $display("FAIL m0_spurious: ack=%b err=%b with nothing outstanding", m0_ack, m0_err);
            end else begin
                e = exp0_q.pop_front();
                if (m0_err !== e.err || m0_ack !== !e.err || (!e.err && m0_rdat !== e.dat)) begin
                    bad++;
                    $display("FAIL m0_rsp: got ack=%b err=%b dat=%h, need err=%b dat=%h",
                             m0_ack, m0_err, m0_rdat, e.err, e.dat);
                end
            end
        end
        if (o_rsp1) begin
            total++;
            if (exp1_q.size() == 0) begin
                bad++;
                $display("FAIL m1_spurious: ack=%b err=%b with nothing outstanding", m1_ack, m1_err);
            end else begin
                e = exp1_q.pop_front();
                if (m1_err !== e.err || m1_ack !== !e.err || (!e.err && m1_rdat !== e.dat)) begin
                    bad++;
                    $display("FAIL m1_rsp: got ack=%b err=%b dat=%h, need err=%b dat=%h",
                             m1_ack, m1_err, m1_rdat, e.err, e.dat);
                end
            end
        end
        n_acc0 += int'(o_acc0);
        n_acc1 += int'(o_acc1);
        n_rsp0 += int'(o_rsp0);
        n_rsp1 += int'(o_rsp1);
        n_ack0 += int'(o_ack0);
        n_err0 += int'(o_err0);

        @(posedge clk);
        #1;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        s_dat_i   = 32'hDEAD_BEEF;
        s_stall_i = stall_req;
        if (inject_ack) begin
            s_ack_i = 1'b1;
        end else if (!hold && slave_q.size() > 0) begin
            r       = slave_q.pop_front();
            s_err_i = r.err;
            s_ack_i = !r.err;
            s_dat_i = r.dat;
        end
    endtask

    task automatic wait_rsp(input int m, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if ((m == 0 ? n_rsp0 : n_rsp1) >= target) break;
            cycle();
        end
    endtask

    task automatic wait_acc(input int m, input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if ((m == 0 ? n_acc0 : n_acc1) >= target) break;
            cycle();
        end
    endtask

    task automatic idle_masters();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_sel = 4'hF; m0_wdat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_sel = 4'h3; m1_wdat = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0; s_dat_i = '0;
        hold = 1'b0; inject_ack = 1'b0; stall_req = 1'b0;
        slave_q.delete(); exp0_q.delete(); exp1_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        total++;
        if (o_scyc !== 1'b0 || o_sstb !== 1'b0) begin
            bad++; $display("FAIL reset_slave: cyc=%b stb=%b, need 0 0", o_scyc, o_sstb);
        end
        total++;
        if (o_stall0 !== 1'b1 || o_stall1 !== 1'b1) begin
            bad++; $display("FAIL reset_stall: stall0=%b stall1=%b, need 1 1", o_stall0, o_stall1);
        end
        total++;
        if (o_cnt !== 0) begin
            bad++; $display("FAIL reset_cnt: out_cnt=%0d, need 0", o_cnt);
        end
        total++;
        if (o_ack0 || o_ack1 || o_err0 || o_err1) begin
            bad++; $display("FAIL reset_rsp: ack0=%b ack1=%b err0=%b err1=%b, need all 0",
                            o_ack0, o_ack1, o_err0, o_err1);
        end
    endtask

    task automatic test_single_m0();
        int idx = 0;
        int b_acc = n_acc0, b_rsp = n_rsp0, b_sstb = n_sstb, b_rsp1 = n_rsp1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 30'h10;
        cycle();
        total++;
        if (o_stall0 !== 1'b1 || o_acc0) begin
            bad++; $display("FAIL arb_latency: stall0=%b, need 1 during arbitration", o_stall0);
        end
        for (int k = 0; k < 30 && (n_rsp0 - b_rsp) < 3; k++) begin
            cycle();
            if (k == 0) begin
                total++;
                if (!o_acc0) begin
                    bad++; $display("FAIL grant_m0: accepted=%b, need 1 one cycle after request", o_acc0);
                end
            end
            if (o_acc0) begin
                idx++;
                if (idx < 3) m0_addr = AW'(30'h10 + idx);
                else         m0_stb = 1'b0;
            end
        end
        total++;
        if (n_sstb - b_sstb !== 3 || n_acc0 - b_acc !== 3) begin
            bad++; $display("FAIL m0_strobes: s_stb pulses=%0d m0 accepts=%0d, need 3",
                            n_sstb - b_sstb, n_acc0 - b_acc);
        end
        total++;
        if (n_rsp0 - b_rsp !== 3 || n_rsp1 - b_rsp1 !== 0) begin
            bad++; $display("FAIL m0_acks: m0 rsps=%0d m1 rsps=%0d, need 3 0",
                            n_rsp0 - b_rsp, n_rsp1 - b_rsp1);
        end
        idle_masters();
    endtask

    task automatic test_contention();
        int gap = -1;
        int t;
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 30'h20;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 30'h30;
        cycle();
        total++;
        if (o_stall0 !== 1'b1 || o_stall1 !== 1'b1) begin
            bad++; $display("FAIL contend_idle: stall0=%b stall1=%b, need 1 1", o_stall0, o_stall1);
        end
        cycle();
        total++;
        if (!o_acc0 || o_acc1 || o_stall1 !== 1'b1) begin
            bad++; $display("FAIL first_grant: acc0=%b acc1=%b stall1=%b, need 1 0 1",
                            o_acc0, o_acc1, o_stall1);
        end
        m0_stb = 1'b0;
        t = n_rsp0 + 1;
        wait_rsp(0, t, 10);
        m0_cyc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 1) begin
                total++;
                if (o_scyc !== 1'b0 || o_stall1 !== 1'b1) begin
                    bad++; $display("FAIL idle_gap: s_cyc=%b stall1=%b, need 0 1", o_scyc, o_stall1);
                end
            end
            if (o_acc1) begin
                gap = k;
                break;
            end
        end
        total++;
        if (gap !== 2) begin
            bad++; $display("FAIL handover: m1 accepted %0d cycles after m0 drop, need 2", gap);
        end
        m1_stb = 1'b0;
        t = n_rsp1 + 1;
        wait_rsp(1, t, 10);
        idle_masters();

        // last grant went to m1, so m0 wins the next tie
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 30'h21;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 30'h31;
        cycle();
        cycle();
        total++;
        if (!o_acc0 || o_acc1) begin
            bad++; $display("FAIL rr_grant: acc0=%b acc1=%b, need m0 granted", o_acc0, o_acc1);
        end
        m0_stb = 1'b0;
        t = n_rsp0 + 1;
        wait_rsp(0, t, 10);
        m0_cyc = 1'b0;
        t = n_acc1 + 1;
        wait_acc(1, t, 10);
        m1_stb = 1'b0;
        t = n_rsp1 + 1;
        wait_rsp(1, t, 10);
        total++;
        if (n_rsp1 !== t) begin
            bad++; $display("FAIL m1_after_m0: m1 rsps=%0d, need %0d", n_rsp1, t);
        end
        idle_masters();
    endtask

    task automatic test_full();
        int b_acc, b_rsp, outst;
        int viol = 0;
        do_reset();
        b_acc = n_acc1; b_rsp = n_rsp1;
        hold = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 30'h200;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (o_acc1) m1_addr = m1_addr + 1'b1;
        end
        total++;
        if (n_acc1 - b_acc !== MAX_OUT) begin
            bad++; $display("FAIL full_accepts: accepted=%0d, need %0d", n_acc1 - b_acc, MAX_OUT);
        end
        total++;
        if (o_stall1 !== 1'b1 || o_sstb !== 1'b0 || o_cnt !== MAX_OUT) begin
            bad++; $display("FAIL full_stall: stall1=%b s_stb=%b out_cnt=%0d, need 1 0 %0d",
                            o_stall1, o_sstb, o_cnt, MAX_OUT);
        end
        hold = 1'b0;
        cycle();
        cycle();
        total++;
        if (!o_rsp1 || o_acc1) begin
            bad++; $display("FAIL full_same_cycle: rsp1=%b acc1=%b, need 1 0", o_rsp1, o_acc1);
        end
        cycle();
        if (o_acc1) m1_addr = m1_addr + 1'b1;
        total++;
        if (!o_acc1) begin
            bad++; $display("FAIL slot_freed: acc1=%b, need 1 after an ack", o_acc1);
        end
        for (int k = 0; k < 40 && (n_rsp1 - b_rsp) < 8; k++) begin
            cycle();
            outst = (n_acc1 - b_acc) - (n_rsp1 - b_rsp);
            if (outst > MAX_OUT) viol++;
            if (o_acc1) m1_addr = m1_addr + 1'b1;
            if (n_acc1 - b_acc >= 8) m1_stb = 1'b0;
        end
        total++;
        if (viol !== 0 || n_rsp1 - b_rsp !== 8 || n_acc1 - b_acc !== 8) begin
            bad++; $display("FAIL stream: violations=%0d accepts=%0d rsps=%0d, need 0 8 8",
                            viol, n_acc1 - b_acc, n_rsp1 - b_rsp);
        end
        idle_masters();
    endtask

    task automatic test_err();
        int b_err, b_ack, t;
        do_reset();
        b_err = n_err0; b_ack = n_ack0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 30'h4000; m0_wdat = 32'h1234_5678;
        stall_req = 1'b1;
        cycle();
        cycle();
        total++;
        if (o_stall0 !== 1'b1 || o_acc0 || o_scyc !== 1'b1) begin
            bad++; $display("FAIL slave_stall: stall0=%b acc0=%b s_cyc=%b, need 1 0 1",
                            o_stall0, o_acc0, o_scyc);
        end
        stall_req = 1'b0;
        t = n_acc0 + 1;
        wait_acc(0, t, 10);
        m0_stb = 1'b0;
        t = n_rsp0 + 1;
        wait_rsp(0, t, 10);
        total++;
        if (n_err0 - b_err !== 1 || n_ack0 - b_ack !== 0) begin
            bad++; $display("FAIL err_route: errs=%0d acks=%0d, need 1 0",
                            n_err0 - b_err, n_ack0 - b_ack);
        end
        cycle();
        total++;
        if (o_cnt !== 0 || o_err0) begin
            bad++; $display("FAIL err_retire: out_cnt=%0d err0=%b, need 0 0", o_cnt, o_err0);
        end
        idle_masters();
        inject_ack = 1'b1;
        cycle();
        inject_ack = 1'b0;
        cycle();
        total++;
        if (o_ack0 || o_ack1 || o_cnt !== 0) begin
            bad++; $display("FAIL idle_ack: ack0=%b ack1=%b out_cnt=%0d, need 0 0 0",
                            o_ack0, o_ack1, o_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int b_rsp0, b_rsp1, t;
        do_reset();
        hold = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = 30'h300;
        t = n_acc1 + 2;
        for (int k = 0; k < 10 && n_acc1 < t; k++) begin
            cycle();
            if (o_acc1) m1_addr = m1_addr + 1'b1;
        end
        m1_stb = 1'b0;
        cycle();
        total++;
        if (o_cnt !== 2) begin
            bad++; $display("FAIL mid_outstanding: out_cnt=%0d, need 2", o_cnt);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        hold = 1'b0;
        exp1_q.delete();
        b_rsp0 = n_rsp0; b_rsp1 = n_rsp1;
        cycle();
        total++;
        if (o_scyc !== 1'b0 || o_sstb !== 1'b0 || o_stall1 !== 1'b1 || o_cnt !== 0) begin
            bad++; $display("FAIL mid_reset: s_cyc=%b s_stb=%b stall1=%b out_cnt=%0d, need 0 0 1 0",
                            o_scyc, o_sstb, o_stall1, o_cnt);
        end
        repeat (4) cycle();
        total++;
        if (n_rsp0 - b_rsp0 !== 0 || n_rsp1 - b_rsp1 !== 0) begin
            bad++; $display("FAIL late_ack: rsp0=%0d rsp1=%0d forwarded, need 0 0",
                            n_rsp0 - b_rsp0, n_rsp1 - b_rsp1);
        end
        idle_masters();
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_contention();
        test_full();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
